// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit; integer truncation of the ratio.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: enqueue handshake plus FIFO status.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output overflow,
    output fifo_count
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO; writes are rejected while full even if a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             pop,
  output logic [7:0]       rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;
  logic             push_s;
  logic             pop_ok_s;

  assign push_s   = wr_en & ~full_r;
  assign pop_ok_s = pop & ~empty_r;

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and the flags derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      count_r    <= count_next_s;
      full_r     <= (count_next_s == CNT_W'(DEPTH));
      empty_r    <= (count_next_s == {CNT_W{1'b0}});
      overflow_r <= wr_en & full_r;
    end
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;
  assign overflow = overflow_r;
  assign count    = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered-output serializer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave wr_bus,
  output logic          uart_tx,
  output logic          tx_busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_e              state_r, state_next_s;
  logic [BAUD_W-1:0]      baud_cnt_r, baud_cnt_next_s;
  logic [IDX_W-1:0]       bit_idx_r, bit_idx_next_s;
  logic [DATA_BITS-1:0]   shift_r, shift_next_s;
  logic                   tx_r, tx_next_s;
  logic                   busy_r, busy_next_s;
  logic                   baud_end_s;
  logic                   pop_s;
  logic                   accept_s;
  logic                   full_s;
  logic                   empty_s;
  logic [7:0]             head_s;

  uart_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_bus.wr_data),
    .wr_en    (wr_bus.wr_en),
    .pop      (pop_s),
    .rd_data  (head_s),
    .full     (full_s),
    .empty    (empty_s),
    .overflow (wr_bus.overflow),
    .count    (wr_bus.fifo_count)
  );

  assign wr_bus.full = full_s;
  assign accept_s    = wr_bus.wr_en & ~full_s;
  assign baud_end_s  = (baud_cnt_r == BAUD_LAST);

  // Serializer next state; tx is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_next_s    = state_r;
    baud_cnt_next_s = baud_cnt_r;
    bit_idx_next_s  = bit_idx_r;
    shift_next_s    = shift_r;
    tx_next_s       = 1'b1;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s           = 1'b1;
          state_next_s    = ST_START;
          baud_cnt_next_s = {BAUD_W{1'b0}};
          shift_next_s    = head_s;
          tx_next_s       = 1'b0;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          state_next_s    = ST_DATA;
          baud_cnt_next_s = {BAUD_W{1'b0}};
          bit_idx_next_s  = {IDX_W{1'b0}};
          tx_next_s       = shift_r[0];
        end else begin
          baud_cnt_next_s = baud_cnt_r + BAUD_W'(1'b1);
          tx_next_s       = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          baud_cnt_next_s = {BAUD_W{1'b0}};
          shift_next_s    = shift_r >> 1;
          if (bit_idx_r == DATA_LAST) begin
            state_next_s   = ST_STOP;
            bit_idx_next_s = {IDX_W{1'b0}};
            tx_next_s      = 1'b1;
          end else begin
            bit_idx_next_s = bit_idx_r + IDX_W'(1'b1);
            tx_next_s      = shift_r[1];
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + BAUD_W'(1'b1);
          tx_next_s       = shift_r[0];
        end
      end
      ST_STOP: begin
        if (baud_end_s) begin
          baud_cnt_next_s = {BAUD_W{1'b0}};
          if (bit_idx_r != STOP_LAST) begin
            bit_idx_next_s = bit_idx_r + IDX_W'(1'b1);
            tx_next_s      = 1'b1;
          end else if (!empty_s) begin
            // Chain straight into the next start bit so frames abut.
            pop_s        = 1'b1;
            state_next_s = ST_START;
            shift_next_s = head_s;
            tx_next_s    = 1'b0;
          end else begin
            state_next_s = ST_IDLE;
            tx_next_s    = 1'b1;
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + BAUD_W'(1'b1);
          tx_next_s       = 1'b1;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        baud_cnt_next_s = {BAUD_W{1'b0}};
        bit_idx_next_s  = {IDX_W{1'b0}};
        tx_next_s       = 1'b1;
      end
    endcase
    // A return to IDLE never coincides with a pop, so the next count is non-zero iff queued or accepted.
    busy_next_s = (state_next_s != ST_IDLE) || !empty_s || accept_s;
  end

  // Serializer registers; reset forces the line high at once and aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_idx_r  <= {IDX_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign uart_tx = tx_r;
  assign tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scheduled writes, per-cycle capture, queue-based line model.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 16;
  localparam int BAUD_DIV   = 10;
  localparam int FRAME      = 10 * BAUD_DIV;
  localparam int MAXN       = 4096;

  logic clk = 1'b0;
  logic rst;
  logic uart_tx;
  logic tx_busy;

  uart_tx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_bus (bus),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       sched_en  [MAXN];
  logic [7:0] sched_dat [MAXN];
  logic       cap_tx    [MAXN];
  logic       cap_busy  [MAXN];
  logic       cap_full  [MAXN];
  logic       cap_ovf   [MAXN];
  logic [4:0] cap_cnt   [MAXN];
  int         model_frames;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < MAXN; i++) begin
      sched_en[i]  = 1'b0;
      sched_dat[i] = 8'h00;
    end
  endtask

  task automatic sched(input int idx, input logic [7:0] d);
    sched_en[idx]  = 1'b1;
    sched_dat[idx] = d;
  endtask

  // Drive the schedule; sample j holds the outputs just after write edge j.
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      bus.wr_en   = sched_en[j];
      bus.wr_data = sched_dat[j];
      @(posedge clk);
      #1;
      cap_tx[j]   = uart_tx;
      cap_busy[j] = tx_busy;
      cap_full[j] = bus.full;
      cap_ovf[j]  = bus.overflow;
      cap_cnt[j]  = bus.fifo_count;
    end
    bus.wr_en = 1'b0;
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int off);
    int slot;
    if (off < 0 || off >= FRAME) return 1'b1;
    slot = off / BAUD_DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Reference: a byte queue, a frame may start when the queue held data before the edge and the line is free.
  task automatic check_run(input string tag, input int n);
    logic [7:0] q[$];
    logic [7:0] sent[$];
    int         starts[$];
    logic [7:0] cur;
    int         cnt_prev, start, free_at;
    bit         pop_m, acc;
    logic       e_tx, e_busy, e_ovf, e_full;
    int         bad_tx, bad_busy, bad_cnt, bad_full, bad_ovf;
    int         f_tx, f_busy, f_cnt, f_full, f_ovf;
    logic [9:0] got;
    cur = 8'h00; start = -100000; free_at = 0;
    bad_tx = 0; bad_busy = 0; bad_cnt = 0; bad_full = 0; bad_ovf = 0;
    f_tx = -1; f_busy = -1; f_cnt = -1; f_full = -1; f_ovf = -1;
    for (int j = 0; j < n; j++) begin
      cnt_prev = q.size();
      pop_m = (cnt_prev > 0) && (j >= free_at);
      if (pop_m) begin
        cur = q.pop_front();
        start = j;
        free_at = j + FRAME;
        starts.push_back(j);
        sent.push_back(cur);
      end
      acc   = sched_en[j] && (cnt_prev < FIFO_DEPTH);
      e_ovf = sched_en[j] && (cnt_prev >= FIFO_DEPTH);
      if (acc) q.push_back(sched_dat[j]);
      e_tx   = line_bit(cur, j - start);
      e_busy = (j < free_at) || (q.size() > 0);
      e_full = (q.size() == FIFO_DEPTH);
      if (cap_tx[j] !== e_tx) begin bad_tx++; if (f_tx < 0) f_tx = j; end
      if (cap_busy[j] !== e_busy) begin bad_busy++; if (f_busy < 0) f_busy = j; end
      if (cap_cnt[j] !== 5'(q.size())) begin bad_cnt++; if (f_cnt < 0) f_cnt = j; end
      if (cap_full[j] !== e_full) begin bad_full++; if (f_full < 0) f_full = j; end
      if (cap_ovf[j] !== e_ovf) begin bad_ovf++; if (f_ovf < 0) f_ovf = j; end
    end
    chk($sformatf("%s_tx_bad_samples first=%0d", tag, f_tx), bad_tx, 0);
    chk($sformatf("%s_busy_bad_samples first=%0d", tag, f_busy), bad_busy, 0);
    chk($sformatf("%s_count_bad_samples first=%0d", tag, f_cnt), bad_cnt, 0);
    chk($sformatf("%s_full_bad_samples first=%0d", tag, f_full), bad_full, 0);
    chk($sformatf("%s_overflow_bad_samples first=%0d", tag, f_ovf), bad_ovf, 0);
    // Mid-bit decode of every complete frame against the byte the model says was sent.
    for (int f = 0; f < starts.size(); f++) begin
      if (starts[f] + FRAME <= n) begin
        for (int b = 0; b < 10; b++) got[b] = cap_tx[starts[f] + b * BAUD_DIV + BAUD_DIV / 2];
        chk($sformatf("%s_frame%0d", tag, f), got, {1'b1, sent[f], 1'b0});
      end
    end
    model_frames = starts.size();
  endtask

  initial begin
    int idx, nb, n, peak;
    logic [7:0] v;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    clear_sched();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_uart_tx", uart_tx, 1'b1);
    chk("reset_tx_busy", tx_busy, 1'b0);
    chk("reset_fifo_count", bus.fifo_count, 5'd0);
    chk("reset_full", bus.full, 1'b0);
    chk("reset_overflow", bus.overflow, 1'b0);
    rst = 1'b0;

    // Idle line for 1000 clocks.
    clear_sched();
    run(1000);
    check_run("idle", 1000);

    // Single byte 0x55.
    clear_sched();
    sched(0, 8'h55);
    run(110);
    check_run("single", 110);
    chk("single_count_after_write", cap_cnt[0], 5'd1);
    chk("single_line_before_start", cap_tx[0], 1'b1);
    chk("single_start_bit", cap_tx[1], 1'b0);
    chk("single_busy_last_frame_clk", cap_busy[100], 1'b1);
    chk("single_busy_after_frame", cap_busy[101], 1'b0);

    // Burst of four on consecutive clocks.
    clear_sched();
    sched(0, 8'h01); sched(1, 8'h80); sched(2, 8'hFF); sched(3, 8'h00);
    run(420);
    check_run("burst", 420);
    peak = 0;
    for (int j = 0; j < 420; j++) if (int'(cap_cnt[j]) > peak) peak = int'(cap_cnt[j]);
    chk("burst_count_peak", peak, 3);
    chk("burst_frames", model_frames, 4);
    chk("burst_busy_end", cap_busy[400], 1'b1);
    chk("burst_idle_after", cap_busy[401], 1'b0);

    // Overflow: fill behind an active frame, 17th write rejected.
    clear_sched();
    v = 8'($urandom);
    sched(0, v);
    for (int i = 0; i < 17; i++) sched(50 + i, 8'(8'h10 + i));
    run(1710);
    check_run("overflow", 1710);
    chk("ovf_full_before_16th", cap_full[64], 1'b0);
    chk("ovf_full_after_16th", cap_full[65], 1'b1);
    chk("ovf_no_pulse_on_accept", cap_ovf[65], 1'b0);
    chk("ovf_pulse", cap_ovf[66], 1'b1);
    chk("ovf_pulse_one_cycle", cap_ovf[67], 1'b0);
    chk("ovf_count_held", cap_cnt[66], 5'd16);
    chk("ovf_frames", model_frames, 17);
    chk("ovf_idle_after", cap_busy[1701], 1'b0);

    // Write on the STOP last cycle with one byte queued.
    clear_sched();
    sched(0, 8'hA5); sched(2, 8'h3C); sched(101, 8'hC3);
    run(320);
    check_run("simul", 320);
    chk("simul_count_before", cap_cnt[100], 5'd1);
    chk("simul_count_held", cap_cnt[101], 5'd1);
    chk("simul_frames", model_frames, 3);

    // Reset during DATA bit 3 with five bytes queued.
    clear_sched();
    sched(0, 8'h00);
    for (int i = 1; i < 6; i++) sched(i, 8'($urandom));
    run(45);
    check_run("rstmid_pre", 45);
    chk("rstmid_line_low_before", uart_tx, 1'b0);
    chk("rstmid_count_before", bus.fifo_count, 5'd5);
    rst = 1'b1;
    #2;
    chk("rstmid_line_high", uart_tx, 1'b1);
    chk("rstmid_count_zero", bus.fifo_count, 5'd0);
    chk("rstmid_busy_low", tx_busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_sched();
    run(300);
    check_run("rstmid_post", 300);

    // Random bytes with random spacing, including idle gaps between frames.
    for (int rep = 0; rep < 3; rep++) begin
      clear_sched();
      idx = 0;
      nb = $urandom_range(4, 8);
      for (int i = 0; i < nb; i++) begin
        sched(idx, 8'($urandom));
        if ($urandom_range(0, 3) == 0) idx += $urandom_range(90, 180);
        else idx += $urandom_range(1, 5);
      end
      n = idx + FRAME * nb + 20;
      run(n);
      check_run($sformatf("rand%0d", rep), n);
      chk($sformatf("rand%0d_frames", rep), model_frames, nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
